// File: rtl/morph_kernel_ctrl_if.sv
// Kernel manager bus: AXI-Stream config beats in, two LUT read ports and status out.
interface morph_kernel_ctrl_if #(
   parameter int KERNEL_WIDTH      = 71,
   parameter int KERNEL_DATA_WIDTH = 8
);
   localparam int AW = $clog2(KERNEL_WIDTH);

   logic signed [KERNEL_DATA_WIDTH-1:0] cfg_tdata;
   logic                                cfg_tvalid;
   logic                                cfg_tready;
   logic                                cfg_tlast;
   logic                                frame_boundary;
   logic [AW-1:0]                       ero_kernel_lut_address;
   logic signed [KERNEL_DATA_WIDTH-1:0] ero_kernel_lut_data;
   logic [AW-1:0]                       dila_kernel_lut_address;
   logic signed [KERNEL_DATA_WIDTH-1:0] dila_kernel_lut_data;
   logic                                pending;
   logic                                swap_done;
   logic                                cfg_error;

   modport master (
      output cfg_tdata, cfg_tvalid, cfg_tlast, frame_boundary,
             ero_kernel_lut_address, dila_kernel_lut_address,
      input  cfg_tready, ero_kernel_lut_data, dila_kernel_lut_data,
             pending, swap_done, cfg_error
   );

   modport slave (
      input  cfg_tdata, cfg_tvalid, cfg_tlast, frame_boundary,
             ero_kernel_lut_address, dila_kernel_lut_address,
      output cfg_tready, ero_kernel_lut_data, dila_kernel_lut_data,
             pending, swap_done, cfg_error
   );
endinterface

// File: rtl/morph_kernel_ctrl.sv
// Double-buffered erosion/dilation kernel store: loads a shadow bank, flips on a frame boundary.
// LUT reads are combinational (0 cycles); cfg_tready is registered and drops only while a set awaits its swap.
module morph_kernel_ctrl #(
   parameter int KERNEL_WIDTH      = 71,
   parameter int KERNEL_DATA_WIDTH = 8
) (
   input logic                clk,
   input logic                areset,
   morph_kernel_ctrl_if.slave bus
);
   localparam int AW   = $clog2(KERNEL_WIDTH);
   localparam int CW   = $clog2(2 * KERNEL_WIDTH);
   localparam int LAST = 2 * KERNEL_WIDTH - 1;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, PENDING} state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          active_sel, active_sel_d;
   logic          cfg_tready_q, pending_q, swap_done_q, cfg_error_q;
   logic          swap_done_d, cfg_error_d;
   logic          accept, wr_en, wr_ero, shadow_sel;
   logic [AW-1:0] wr_idx;

   logic signed [KERNEL_DATA_WIDTH-1:0] ero_mem [2][KERNEL_WIDTH];
   logic signed [KERNEL_DATA_WIDTH-1:0] dil_mem [2][KERNEL_WIDTH];

   assign shadow_sel = ~active_sel;
   assign accept     = bus.cfg_tvalid & cfg_tready_q;
   assign wr_ero     = cnt < CW'(KERNEL_WIDTH);
   assign wr_idx     = wr_ero ? AW'(cnt) : AW'(cnt - CW'(KERNEL_WIDTH));

   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      active_sel_d = active_sel;
      swap_done_d  = 1'b0;
      cfg_error_d  = 1'b0;
      wr_en        = 1'b0;
      case (state)
         IDLE, LOAD: begin
            if (accept) begin
               wr_en = 1'b1;
               if (bus.cfg_tlast) begin
                  cnt_d = '0;
                  if (cnt == CW'(LAST)) begin
                     state_d = PENDING;
                  end else begin
                     cfg_error_d = 1'b1;
                     state_d     = IDLE;
                  end
               end else if (cnt == CW'(LAST)) begin
                  // Full set without tlast: swallow beats until the sender's tlast resyncs us.
                  cfg_error_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = DRAIN;
               end else begin
                  cnt_d   = cnt + 1'b1;
                  state_d = LOAD;
               end
            end
         end
         DRAIN: begin
            if (accept && bus.cfg_tlast) state_d = IDLE;
         end
         PENDING: begin
            if (bus.frame_boundary) begin
               active_sel_d = ~active_sel;
               swap_done_d  = 1'b1;
               cnt_d        = '0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state        <= IDLE;
         cnt          <= '0;
         active_sel   <= 1'b0;
         cfg_tready_q <= 1'b0;
         pending_q    <= 1'b0;
         swap_done_q  <= 1'b0;
         cfg_error_q  <= 1'b0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         active_sel   <= active_sel_d;
         cfg_tready_q <= (state_d != PENDING);
         pending_q    <= (state_d == PENDING);
         swap_done_q  <= swap_done_d;
         cfg_error_q  <= cfg_error_d;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < KERNEL_WIDTH; i++) begin
               ero_mem[b][i] <= '0;
               dil_mem[b][i] <= '0;
            end
         end
      end else if (wr_en) begin
         if (wr_ero) ero_mem[shadow_sel][wr_idx] <= bus.cfg_tdata;
         else        dil_mem[shadow_sel][wr_idx] <= bus.cfg_tdata;
      end
   end

   assign bus.ero_kernel_lut_data  = (bus.ero_kernel_lut_address < AW'(KERNEL_WIDTH))
                                     ? ero_mem[active_sel][bus.ero_kernel_lut_address] : '0;
   assign bus.dila_kernel_lut_data = (bus.dila_kernel_lut_address < AW'(KERNEL_WIDTH))
                                     ? dil_mem[active_sel][bus.dila_kernel_lut_address] : '0;
   assign bus.cfg_tready = cfg_tready_q;
   assign bus.pending    = pending_q;
   assign bus.swap_done  = swap_done_q;
   assign bus.cfg_error  = cfg_error_q;
endmodule

// File: tb/tb_morph_kernel_ctrl.sv
// Bench for morph_kernel_ctrl: queue-based reference model checked every cycle plus literal spot checks.
module tb_morph_kernel_ctrl;
   localparam int KW = 71;
   localparam int DW = 8;

   logic clk    = 1'b0;
   logic areset = 1'b0;

   morph_kernel_ctrl_if #(.KERNEL_WIDTH(KW), .KERNEL_DATA_WIDTH(DW)) bus ();

   morph_kernel_ctrl #(.KERNEL_WIDTH(KW), .KERNEL_DATA_WIDTH(DW)) dut (
      .clk    (clk),
      .areset (areset),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: shadow set is simply the list of beats received so far.
   int m_ero [KW];
   int m_dil [KW];
   int q [$];
   bit m_rdy, m_pend, m_swap, m_err, m_drain;

   initial begin
      for (int i = 0; i < KW; i++) begin
         m_ero[i] = 0;
         m_dil[i] = 0;
      end
      forever begin
         @(posedge clk or posedge areset);
         if (areset) begin
            for (int i = 0; i < KW; i++) begin
               m_ero[i] = 0;
               m_dil[i] = 0;
            end
            q.delete();
            m_rdy = 0; m_pend = 0; m_swap = 0; m_err = 0; m_drain = 0;
         end else begin
            m_swap = 0;
            m_err  = 0;
            if (m_pend) begin
               if (bus.frame_boundary) begin
                  for (int t = 0; t < KW; t++) begin
                     m_ero[t] = q[t];
                     m_dil[t] = q[KW + t];
                  end
                  q.delete();
                  m_pend = 0;
                  m_swap = 1;
               end
            end else if (m_rdy && bus.cfg_tvalid) begin
               if (m_drain) begin
                  if (bus.cfg_tlast) m_drain = 0;
               end else begin
                  q.push_back(int'(bus.cfg_tdata));
                  if (bus.cfg_tlast) begin
                     if (q.size() == 2 * KW) m_pend = 1;
                     else begin
                        m_err = 1;
                        q.delete();
                     end
                  end else if (q.size() == 2 * KW) begin
                     m_err   = 1;
                     m_drain = 1;
                     q.delete();
                  end
               end
            end
            m_rdy = !m_pend;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: dut=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_read(input int addr, input bit ero);
      if (addr >= KW) return 0;
      return ero ? m_ero[addr] : m_dil[addr];
   endfunction

   task automatic compare_outputs();
      check("cfg_tready", int'(bus.cfg_tready), int'(m_rdy));
      check("pending",    int'(bus.pending),    int'(m_pend));
      check("swap_done",  int'(bus.swap_done),  int'(m_swap));
      check("cfg_error",  int'(bus.cfg_error),  int'(m_err));
      check("ero_data",   int'(bus.ero_kernel_lut_data),
            exp_read(int'(bus.ero_kernel_lut_address), 1'b1));
      check("dila_data",  int'(bus.dila_kernel_lut_data),
            exp_read(int'(bus.dila_kernel_lut_address), 1'b0));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      compare_outputs();
      @(negedge clk);
   endtask

   function automatic int beat_val(input int kind, input int b);
      int t;
      bit ero;
      ero = (b < KW);
      t   = ero ? b : b - KW;
      case (kind)
         0:       return ero ? t - 35 : 35 - t;
         1:       return 7;
         default: return ero ? -(t % 20) : (t % 13) + 1;
      endcase
   endfunction

   task automatic send(input int kind, input int nbeats, input int tlast_at,
                       input int fb_at, input bit gaps);
      for (int b = 0; b < nbeats; b++) begin
         bus.cfg_tvalid              = 1'b1;
         bus.cfg_tdata               = 8'(beat_val(kind, b));
         bus.cfg_tlast               = (b == tlast_at);
         bus.frame_boundary          = (b == fb_at);
         bus.ero_kernel_lut_address  = 7'(b % 128);
         bus.dila_kernel_lut_address = 7'((b * 3) % 128);
         tick();
         if (gaps && (b % 7 == 3)) begin
            bus.cfg_tvalid     = 1'b0;
            bus.cfg_tlast      = 1'b0;
            bus.frame_boundary = 1'b0;
            tick();
         end
      end
      bus.cfg_tvalid     = 1'b0;
      bus.cfg_tlast      = 1'b0;
      bus.frame_boundary = 1'b0;
   endtask

   task automatic pulse_fb();
      bus.frame_boundary = 1'b1;
      tick();
      bus.frame_boundary = 1'b0;
   endtask

   task automatic lit_reads(input int ea, input int da, input int e_exp, input int d_exp,
                            input string tag);
      bus.ero_kernel_lut_address  = 7'(ea);
      bus.dila_kernel_lut_address = 7'(da);
      #1;
      check({tag, "_ero"},  int'(bus.ero_kernel_lut_data),  e_exp);
      check({tag, "_dila"}, int'(bus.dila_kernel_lut_data), d_exp);
   endtask

   initial begin
      bus.cfg_tvalid              = 1'b0;
      bus.cfg_tdata               = '0;
      bus.cfg_tlast               = 1'b0;
      bus.frame_boundary          = 1'b0;
      bus.ero_kernel_lut_address  = 7'd5;
      bus.dila_kernel_lut_address = 7'd5;
      areset = 1'b1;
      repeat (3) tick();
      check("rst_tready_low", int'(bus.cfg_tready), 0);
      lit_reads(5, 5, 0, 0, "rst_addr5");
      areset = 1'b0;
      tick();
      check("tready_after_release", int'(bus.cfg_tready), 1);
      check("rst_pending", int'(bus.pending), 0);

      // Nominal load and swap
      send(0, 2 * KW, 2 * KW - 1, -1, 1'b0);
      check("nominal_pending", int'(bus.pending), 1);
      check("nominal_tready",  int'(bus.cfg_tready), 0);
      lit_reads(0, 0, 0, 0, "pre_swap");
      repeat (2) tick();
      pulse_fb();
      check("nominal_swap_done", int'(bus.swap_done), 1);
      lit_reads(0, 0, -35, 35, "post_swap_addr0");
      lit_reads(70, 70, 35, -35, "post_swap_addr70");
      tick();
      check("swap_done_one_cycle", int'(bus.swap_done), 0);

      // Second load of all 7s with valid gaps
      send(1, 2 * KW, 2 * KW - 1, -1, 1'b1);
      lit_reads(10, 10, -25, 25, "hold_old_bank");
      pulse_fb();
      lit_reads(10, 70, 7, 7, "sevens");
      for (int a = 0; a < 128; a++) begin
         bus.ero_kernel_lut_address  = 7'(a);
         bus.dila_kernel_lut_address = 7'(127 - a);
         tick();
      end

      // Early tlast on beat 10
      send(2, 11, 10, -1, 1'b0);
      check("early_tlast_error", int'(bus.cfg_error), 1);
      lit_reads(3, 3, 7, 7, "early_unchanged");
      tick();
      check("early_error_pulse", int'(bus.cfg_error), 0);
      send(0, 2 * KW, 2 * KW - 1, -1, 1'b0);
      pulse_fb();
      lit_reads(0, 0, -35, 35, "recover_swap");

      // Missing tlast, then drained tail
      send(2, 2 * KW, -1, -1, 1'b0);
      check("missing_tlast_error", int'(bus.cfg_error), 1);
      send(2, 3, 2, -1, 1'b0);
      tick();
      pulse_fb();
      check("drain_no_swap", int'(bus.swap_done), 0);
      lit_reads(0, 0, -35, 35, "drain_unchanged");

      // Boundary coincident with final beat
      send(2, 2 * KW, 2 * KW - 1, 2 * KW - 1, 1'b0);
      check("coincide_no_swap", int'(bus.swap_done), 0);
      check("coincide_pending", int'(bus.pending), 1);
      tick();
      pulse_fb();
      check("coincide_later_swap", int'(bus.swap_done), 1);
      lit_reads(1, 0, -1, 1, "kind2_vals");
      lit_reads(100, 127, 0, 0, "out_of_range");
      tick();

      // Reset while pending
      send(0, 2 * KW, 2 * KW - 1, -1, 1'b0);
      bus.ero_kernel_lut_address  = 7'd1;
      bus.dila_kernel_lut_address = 7'd0;
      areset = 1'b1;
      #1;
      check("arst_ero",     int'(bus.ero_kernel_lut_data), 0);
      check("arst_dila",    int'(bus.dila_kernel_lut_data), 0);
      check("arst_pending", int'(bus.pending), 0);
      check("arst_tready",  int'(bus.cfg_tready), 0);
      tick();
      areset = 1'b0;
      tick();
      check("arst_tready_back", int'(bus.cfg_tready), 1);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
